// File: rtl/ls_unit.sv
// ls_unit: registered load/store lane with independent capture registers.
// The store path is built only when LS_UNIT_STORE_PATH_EN is defined; otherwise its outputs are tied to 0.
module ls_unit #(
  parameter int data_width = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  load_enable,
  input  logic                  store_enable,
  input  logic [data_width-1:0] data_load_input,
  output logic [data_width-1:0] data_load_output,
  input  logic [data_width-1:0] data_store_input,
  output logic [data_width-1:0] data_store_output,
  output logic                  load_valid,
  output logic                  store_valid
);
  logic [data_width-1:0] load_reg_d, load_reg_q;
  logic                  load_valid_d, load_valid_q;
  logic                  load_cap;
  always_comb begin
    load_cap     = enable && load_enable;
    load_reg_d   = load_cap ? data_load_input : load_reg_q;
    load_valid_d = load_valid_q || load_cap;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      load_reg_q   <= '0;
      load_valid_q <= 1'b0;
    end else begin
      load_reg_q   <= load_reg_d;
      load_valid_q <= load_valid_d;
    end
  end
  assign data_load_output = load_reg_q;
  assign load_valid       = load_valid_q;
`ifdef LS_UNIT_STORE_PATH_EN
  logic [data_width-1:0] store_reg_d, store_reg_q;
  logic                  store_valid_d, store_valid_q;
  logic                  store_cap;
  always_comb begin
    store_cap     = enable && store_enable;
    store_reg_d   = store_cap ? data_store_input : store_reg_q;
    store_valid_d = store_valid_q || store_cap;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      store_reg_q   <= '0;
      store_valid_q <= 1'b0;
    end else begin
      store_reg_q   <= store_reg_d;
      store_valid_q <= store_valid_d;
    end
  end
  assign data_store_output = store_reg_q;
  assign store_valid       = store_valid_q;
`else
  // Weight lanes leave the store inputs undriven; they are deliberately ignored here.
  logic store_unused;
  assign store_unused      = ^{store_enable, data_store_input};
  assign data_store_output = '0;
  assign store_valid       = 1'b0;
`endif
endmodule

// File: tb/tb_ls_unit.sv
// tb_ls_unit: directed plus randomized checks of ls_unit against a cycle-level reference model.
module tb_ls_unit;
  localparam int W = 64;
  logic         clk = 1'b0;
  logic         reset_n, enable, load_enable, store_enable;
  logic [W-1:0] data_load_input, data_store_input;
  logic [W-1:0] data_load_output, data_store_output;
  logic         load_valid, store_valid;
  logic [W-1:0] exp_load, exp_store;
  logic         exp_lv, exp_sv;
  int           passed = 0, total = 0;

  ls_unit #(.data_width(W)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .load_enable(load_enable), .store_enable(store_enable),
    .data_load_input(data_load_input), .data_load_output(data_load_output),
    .data_store_input(data_store_input), .data_store_output(data_store_output),
    .load_valid(load_valid), .store_valid(store_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic drive(input logic rn, input logic en, input logic ld, input logic st,
                       input logic [W-1:0] dl, input logic [W-1:0] ds);
    reset_n = rn; enable = en; load_enable = ld; store_enable = st;
    data_load_input = dl; data_store_input = ds;
  endtask

  // Advance one clock: the model applies the capture rules to the inputs present at the edge.
  task automatic step();
    @(posedge clk);
    if (!reset_n) begin
      exp_load = '0; exp_lv = 1'b0; exp_store = '0; exp_sv = 1'b0;
    end else if (enable) begin
      if (load_enable) begin exp_load = data_load_input; exp_lv = 1'b1; end
`ifdef LS_UNIT_STORE_PATH_EN
      if (store_enable) begin exp_store = data_store_input; exp_sv = 1'b1; end
`endif
    end
    #1;
    check("load_data", data_load_output, exp_load);
    check("load_valid", W'(load_valid), W'(exp_lv));
    check("store_data", data_store_output, exp_store);
    check("store_valid", W'(store_valid), W'(exp_sv));
  endtask

  initial begin
    exp_load = '0; exp_store = '0; exp_lv = 1'b0; exp_sv = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0002);
    step(); step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001, '0);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, '0);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, '0);
    step(); step();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h55);
    step(); step();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA);
    step(); step();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 64'h11, 64'h22);
    step();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, W'(i), 64'h99);
      step();
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 64'h77, 64'h88);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 64'h33, 64'h44);
    step();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, {$urandom, $urandom}, {$urandom, $urandom});
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ls_unit.md
LS_UNIT -- requirements
Module: ls_unit

Interface
REQ-001 The module SHALL have parameter data_width, default 64, giving the width in bits of each data path.
REQ-002 The module SHALL have port clk, input, 1 bit, the rising-edge clock for all state.
REQ-003 The module SHALL have port reset_n, input, 1 bit; reset is synchronous, active-low.
REQ-004 The module SHALL have port enable, input, 1 bit, the master lane enable (precision-decoded lane enable ANDed with array enable).
REQ-005 The module SHALL have port load_enable, input, 1 bit, which captures data_load_input.
REQ-006 The module SHALL have port store_enable, input, 1 bit, which captures data_store_input.
REQ-007 The module SHALL have port data_load_input, input, data_width bits, the activation or weight word from the inverse mux.
REQ-008 The module SHALL have port data_load_output, output, data_width bits, the registered load word driven to the filter/select stage.
REQ-009 The module SHALL have port data_store_input, input, data_width bits, the compacted MXU result word.
REQ-010 The module SHALL have port data_store_output, output, data_width bits, the registered store word driven to the output FIFO mux.
REQ-011 The module SHALL have port load_valid, output, 1 bit, set when the load register holds captured data.
REQ-012 The module SHALL have port store_valid, output, 1 bit, set when the store register holds captured data.

Function
REQ-013 The module SHALL contain two independent data_width-bit registers: load_reg and store_reg.
- data_load_output = load_reg.
- data_store_output = store_reg.
- Outputs are purely registered, with no combinational input-to-output path.
REQ-014 On each rising clk edge with reset_n=1 and enable=1 and load_enable=1, the module SHALL capture data_load_input into load_reg and set load_valid=1.
- Latency: 1 cycle.
REQ-015 On each rising clk edge with reset_n=1 and enable=1 and store_enable=1, the module SHALL capture data_store_input into store_reg and set store_valid=1.
- Latency: 1 cycle.
REQ-016 With load_enable and store_enable both asserted in the same cycle, both captures SHALL occur in that cycle without mutual interference.
REQ-017 With enable=0, the module SHALL hold load_reg, store_reg, load_valid and store_valid unchanged, regardless of load_enable and store_enable.
REQ-018 With enable=1 and a given strobe low, the corresponding register and valid flag SHALL hold their values.
- There is no auto-clear.
REQ-019 Back-to-back strobes SHALL capture a new word every cycle, with no bubble.
REQ-020 An undriven store_enable or data_store_input (weight lanes) SHALL NOT affect load_reg, data_load_output or load_valid.

Reset
REQ-021 When reset_n=0 at a rising clk edge, the module SHALL clear load_reg, store_reg, load_valid and store_valid to 0.
- Reset overrides enable and both strobes.
REQ-022 When reset_n is asserted mid-stream, the module SHALL discard any capture requested in that same cycle, and the outputs SHALL read 0 from the next cycle.
REQ-023 The first capture after reset_n deasserts SHALL occur on the first edge with reset_n=1 and the relevant enable conditions true.

Configuration
REQ-024 The store path SHALL be compiled in only when macro LS_UNIT_STORE_PATH_EN is defined.
- With LS_UNIT_STORE_PATH_EN defined: REQ-015 and REQ-016 apply.
- Without it: store_reg is not implemented, data_store_output=0 and store_valid=0 constantly, and store_enable and data_store_input are ignored.
- The load path is identical in both builds.

Verification
REQ-025 Reset check:
- Stimulus: reset_n=0 for 2 cycles with enable=1, load_enable=1, data_load_input=64'hDEAD_BEEF_0000_0001.
- Response: data_load_output=0 and load_valid=0 throughout; after release, captures on the first edge.
REQ-026 Load capture:
- Stimulus: enable=1, load_enable=1, data_load_input=64'h0123_4567_89AB_CDEF for one cycle, then load_enable=0 and the input changed to 64'hFFFF_FFFF_FFFF_FFFF.
- Response: data_load_output=64'h0123_4567_89AB_CDEF one cycle after the strobe and held thereafter.
REQ-027 Disabled lane:
- Stimulus: enable=0, load_enable=1, store_enable=1, both data inputs=64'hAAAA_AAAA_AAAA_AAAA.
- Response: both outputs unchanged from their prior value and both valid flags unchanged.
REQ-028 Simultaneous strobes (store path built):
- Stimulus: load=64'h11, store=64'h22 in the same cycle.
- Response: next cycle data_load_output=64'h11, data_store_output=64'h22, both valid=1.
REQ-029 Streaming:
- Stimulus: load_enable held high for 4 cycles with inputs 1, 2, 3, 4.
- Response: data_load_output=1, 2, 3, 4 on consecutive cycles, each 1-cycle delayed.
REQ-030 Store path compiled out:
- Stimulus: build without LS_UNIT_STORE_PATH_EN, store_enable=1, data_store_input=64'h55.
- Response: data_store_output=0 and store_valid=0 always.
